seg_scan_driver: RTL

Time-multiplexed scan controller for the 4-digit 7-segment display. It generates the 2-bit digit-select `signal` consumed directly by the downstream anode decoder. It also supplies the matching 4-bit nibble and decimal point for the segment decoder. A per-slot blanking interval suppresses ghosting, and a shadow register commits new display values only at frame boundaries to prevent tearing.

---
 rtl/seg_scan_driver.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// 4-digit 7-segment scan controller with per-slot blanking and frame-synchronous display update.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits (digits 3..1).
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  output logic [1:0]  signal,
  output logic        digit_en,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    sig_nxt;
  logic [15:0]   act_val, act_val_nxt, shd_val, shd_val_nxt;
  logic [3:0]    act_dp, act_dp_nxt, shd_dp, shd_dp_nxt;
  logic          pending, pending_nxt;
  logic          frame_end;
  logic          lit;
  logic          en_nxt;
  logic [3:0]    nibble_nxt;
  logic          dp_nxt;
  logic          fd_nxt;

  // Slot sequencing
  always_comb begin
    frame_end = enable && (state != IDLE) && (signal == 2'd3) && (cnt == LAST);
    cnt_nxt   = '0;
    sig_nxt   = '0;
    state_nxt = IDLE;
    if (enable) begin
      if (state != IDLE) begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          sig_nxt = signal + 2'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
          sig_nxt = signal;
        end
      end
      state_nxt = (cnt_nxt < BLK) ? BLANK : SHOW;
    end
  end

  // A load coinciding with the frame end bypasses the shadow so the newest value wins.
  always_comb begin
    act_val_nxt = act_val;
    act_dp_nxt  = act_dp;
    shd_val_nxt = shd_val;
    shd_dp_nxt  = shd_dp;
    pending_nxt = pending;
    if (state == IDLE) begin
      if (load) begin
        act_val_nxt = value_in;
        act_dp_nxt  = dp_in;
        pending_nxt = 1'b0;
      end
    end else if (frame_end) begin
      if (load) begin
        act_val_nxt = value_in;
        act_dp_nxt  = dp_in;
      end else if (pending) begin
        act_val_nxt = shd_val;
        act_dp_nxt  = shd_dp;
      end
      pending_nxt = 1'b0;
    end else if (load) begin
      shd_val_nxt = value_in;
      shd_dp_nxt  = dp_in;
      pending_nxt = 1'b1;
    end
  end

  // Output values for the upcoming cycle, so registered outputs align with signal
  always_comb begin
    nibble_nxt = act_val_nxt[{sig_nxt, 2'b00} +: 4];
    dp_nxt     = act_dp_nxt[sig_nxt];
`ifdef LEADING_ZERO_BLANK_EN
    unique case (sig_nxt)
      2'd0:    lit = 1'b1;
      2'd1:    lit = act_dp_nxt[1] | (|act_val_nxt[15:4]);
      2'd2:    lit = act_dp_nxt[2] | (|act_val_nxt[15:8]);
      default: lit = act_dp_nxt[3] | (|act_val_nxt[15:12]);
    endcase
`else
    lit = 1'b1;
`endif
    en_nxt = (state_nxt == SHOW) && lit;
    fd_nxt = (state_nxt != IDLE) && (sig_nxt == 2'd3) && (cnt_nxt == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      signal     <= '0;
      digit_en   <= 1'b0;
      nibble     <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      shd_val    <= '0;
      shd_dp     <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      signal     <= sig_nxt;
      digit_en   <= en_nxt;
      nibble     <= nibble_nxt;
      dp         <= dp_nxt;
      frame_done <= fd_nxt;
      act_val    <= act_val_nxt;
      act_dp     <= act_dp_nxt;
      shd_val    <= shd_val_nxt;
      shd_dp     <= shd_dp_nxt;
      pending    <= pending_nxt;
    end
  end

endmodule
